bcd_to_byte: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the codebase's byte-to-BCD display path. It takes three BCD digits (hundreds/tens/units), e.g. from keypad or switch entry, and produces an 8-bit binary value for the processor datapath. It uses reverse double-dabble, one bit per clock, with a start/busy/done handshake.

---
 rtl/bcd_to_byte_pkg.sv | 29 ++
 rtl/bcd_to_byte_if.sv | 22 ++
 rtl/bcd_digit_corrector.sv | 16 +
 rtl/bcd_to_byte.sv | 135 +++++++++++++
 tb/tb_bcd_to_byte.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_to_byte_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter.
// Optional build macro used by bcd_to_byte: BCD_SATURA_EN.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DESLOCA,
      FIM
   } estado_t;

   localparam int unsigned BCD_W   = 4;
   localparam int unsigned DIGITOS = 3;
   localparam int unsigned LARGURA = 8;

   localparam logic [3:0] CORRECAO   = 4'd3;
   localparam logic [3:0] LIMIAR     = 4'd8;
   localparam logic [3:0] DIGITO_MAX = 4'd9;

   // True when any packed digit is outside 0..9.
   function automatic logic tem_digito_invalido(input logic [DIGITOS*BCD_W-1:0] bcd);
      logic inv;
      inv = 1'b0;
      for (int unsigned i = 0; i < DIGITOS; i++) begin
         if (bcd[i*BCD_W +: BCD_W] > DIGITO_MAX) inv = 1'b1;
      end
      return inv;
   endfunction

endpackage

// File: rtl/bcd_to_byte_if.sv
// bcd_to_byte_if: start/busy/done handshake, BCD digits in, binary result out.
interface bcd_to_byte_if;
   logic       iniciar;
   logic [3:0] centenas;
   logic [3:0] dezenas;
   logic [3:0] unitarios;
   logic [7:0] dado_byte;
   logic       pronto;
   logic       ocupado;
   logic       overflow;
   logic       digito_invalido;

   modport master (
      output iniciar, centenas, dezenas, unitarios,
      input  dado_byte, pronto, ocupado, overflow, digito_invalido
   );

   modport slave (
      input  iniciar, centenas, dezenas, unitarios,
      output dado_byte, pronto, ocupado, overflow, digito_invalido
   );
endinterface

// File: rtl/bcd_digit_corrector.sv
// bcd_digit_corrector: reverse double-dabble correction for one BCD digit
// (subtract 3 when the shifted digit is 8 or more).
module bcd_digit_corrector
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digito_in,
   output logic [BCD_W-1:0] digito_out
);

   // Conditional subtract-3 after each right shift.
   always_comb begin
      digito_out = digito_in;
      if (digito_in >= LIMIAR) digito_out = digito_in - CORRECAO;
   end

endmodule

// File: rtl/bcd_to_byte.sv
// bcd_to_byte: sequential three-digit BCD to 8-bit binary converter using
// reverse double-dabble, one shift per clock.
// Build macro BCD_SATURA_EN: when defined, an overflowing result reads 8'hFF
// instead of value mod 256.
module bcd_to_byte
   import bcd_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   bcd_to_byte_if.slave  bus
);

   localparam int unsigned BCD_TOT = DIGITOS * BCD_W;
   localparam logic [3:0]  ULTIMO  = 4'(LARGURA - 1);

   estado_t              estado_q, estado_d;
   logic [BCD_TOT-1:0]   bcd_q, bcd_d;
   logic [LARGURA-1:0]   bin_q, bin_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 inv_chk_q, inv_chk_d;
   logic [7:0]           dado_q, dado_d;
   logic                 pronto_q, pronto_d;
   logic                 ocupado_q, ocupado_d;
   logic                 ovf_q, ovf_d;
   logic                 dinv_q, dinv_d;

   logic [BCD_TOT-1:0]   bcd_desl;
   logic [BCD_TOT-1:0]   bcd_corr;
   logic [LARGURA-1:0]   bin_desl;

   // One step of the 20-bit {bcd,bin} right shift.
   always_comb begin
      bcd_desl = {1'b0, bcd_q[BCD_TOT-1:1]};
      bin_desl = {bcd_q[0], bin_q[LARGURA-1:1]};
   end

   for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
      bcd_digit_corrector u_corr (
         .digito_in  (bcd_desl[g*BCD_W +: BCD_W]),
         .digito_out (bcd_corr[g*BCD_W +: BCD_W])
      );
   end

   // Next-state, datapath and registered-output logic; outputs only move on
   // the edge that enters FIM (the 8th shift), so they use the freshly
   // shifted values rather than the registers.
   always_comb begin
      estado_d  = estado_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      inv_chk_d = inv_chk_q;
      dado_d    = dado_q;
      pronto_d  = 1'b0;
      ocupado_d = ocupado_q;
      ovf_d     = ovf_q;
      dinv_d    = dinv_q;

      unique case (estado_q)
         IDLE: begin
            if (bus.iniciar) begin
               bcd_d     = {bus.centenas, bus.dezenas, bus.unitarios};
               bin_d     = '0;
               cnt_d     = '0;
               inv_chk_d = tem_digito_invalido({bus.centenas, bus.dezenas, bus.unitarios});
               ocupado_d = 1'b1;
               estado_d  = DESLOCA;
            end
         end
         DESLOCA: begin
            bcd_d = bcd_corr;
            bin_d = bin_desl;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == ULTIMO) begin
               estado_d = FIM;
               pronto_d = 1'b1;
               dinv_d   = inv_chk_q;
               if (inv_chk_q) begin
                  dado_d = '0;
                  ovf_d  = 1'b0;
               end else begin
                  ovf_d = |bcd_corr;
`ifdef BCD_SATURA_EN
                  dado_d = (|bcd_corr) ? 8'hFF : bin_desl;
`else
                  dado_d = bin_desl;
`endif
               end
            end
         end
         FIM: begin
            ocupado_d = 1'b0;
            estado_d  = IDLE;
         end
         default: begin
            ocupado_d = 1'b0;
            estado_d  = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q  <= IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         inv_chk_q <= 1'b0;
         dado_q    <= '0;
         pronto_q  <= 1'b0;
         ocupado_q <= 1'b0;
         ovf_q     <= 1'b0;
         dinv_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         inv_chk_q <= inv_chk_d;
         dado_q    <= dado_d;
         pronto_q  <= pronto_d;
         ocupado_q <= ocupado_d;
         ovf_q     <= ovf_d;
         dinv_q    <= dinv_d;
      end
   end

   assign bus.dado_byte       = dado_q;
   assign bus.pronto          = pronto_q;
   assign bus.ocupado         = ocupado_q;
   assign bus.overflow        = ovf_q;
   assign bus.digito_invalido = dinv_q;

endmodule

// File: tb/tb_bcd_to_byte.sv
// tb_bcd_to_byte: directed self-checking bench for bcd_to_byte.
// Honours BCD_SATURA_EN when choosing expected overflow results.
module tb_bcd_to_byte;

   logic clock;
   logic reset_n;

   int unsigned tests_run;
   int unsigned tests_failed;

   bcd_to_byte_if bus ();

   bcd_to_byte dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts a conversion from an IDLE cycle and checks latency, busy length,
   // results and the return to IDLE. Ends #1 after edge k+9.
   task automatic run_conv(input string tag, input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] u, input logic [7:0] e_dado,
                           input logic e_ovf, input logic e_inv);
      int unsigned n;
      int unsigned busy;
      logic        got;
      bus.centenas  = c;
      bus.dezenas   = d;
      bus.unitarios = u;
      bus.iniciar   = 1'b1;
      @(posedge clock); #1;
      bus.iniciar = 1'b0;
      busy = bus.ocupado ? 1 : 0;
      got  = 1'b0;
      n    = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(posedge clock); #1;
         if (bus.ocupado) busy++;
         if (bus.pronto) begin
            got = 1'b1;
            n   = i;
         end
      end
      chk({tag, "_lat"},  n, 8);
      chk({tag, "_busy"}, busy, 9);
      chk({tag, "_dado"}, bus.dado_byte, e_dado);
      chk({tag, "_ovf"},  bus.overflow, e_ovf);
      chk({tag, "_inv"},  bus.digito_invalido, e_inv);
      @(posedge clock); #1;
      chk({tag, "_pronto_off"},  bus.pronto, 1'b0);
      chk({tag, "_ocupado_off"}, bus.ocupado, 1'b0);
      chk({tag, "_dado_held"},   bus.dado_byte, e_dado);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned  pcount;
      logic [7:0]   dado5;
      logic         ocup9;
      logic         ocup10;
      logic         pronto18;
      logic [7:0]   dado18;
      logic [7:0]   e_ovf_300;
      logic [7:0]   e_ovf_999;

`ifdef BCD_SATURA_EN
      e_ovf_300 = 8'hFF;
      e_ovf_999 = 8'hFF;
`else
      e_ovf_300 = 8'h2C;
      e_ovf_999 = 8'hE7;
`endif

      tests_run     = 0;
      tests_failed  = 0;
      reset_n       = 1'b0;
      bus.iniciar   = 1'b0;
      bus.centenas  = '0;
      bus.dezenas   = '0;
      bus.unitarios = '0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_dado",    bus.dado_byte, 8'h00);
      chk("rst_pronto",  bus.pronto, 1'b0);
      chk("rst_ocupado", bus.ocupado, 1'b0);
      chk("rst_ovf",     bus.overflow, 1'b0);
      chk("rst_inv",     bus.digito_invalido, 1'b0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Plan 1..4: basic values, overflow and invalid digits
      run_conv("c255", 4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0);
      run_conv("c000", 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
      run_conv("c128", 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0);
      run_conv("c300", 4'd3, 4'd0, 4'd0, e_ovf_300, 1'b1, 1'b0);
      run_conv("c999", 4'd9, 4'd9, 4'd9, e_ovf_999, 1'b1, 1'b0);
      run_conv("c1A3", 4'd1, 4'hA, 4'd3, 8'h00, 1'b0, 1'b1);
      run_conv("c256", 4'd2, 4'd5, 4'd6,
`ifdef BCD_SATURA_EN
               8'hFF,
`else
               8'h00,
`endif
               1'b1, 1'b0);

      // Plan 2: sweep every in-range value
      for (int v = 0; v < 256; v++) begin
         run_conv("sweep", 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 8'(v), 1'b0, 1'b0);
      end

      // Plan 5: iniciar during DESLOCA and FIM ignored; restart at k+10
      bus.centenas  = 4'd0;
      bus.dezenas   = 4'd4;
      bus.unitarios = 4'd2;
      bus.iniciar   = 1'b1;
      @(posedge clock); #1;
      bus.iniciar   = 1'b0;
      bus.centenas  = 4'd1;
      bus.dezenas   = 4'd0;
      bus.unitarios = 4'd7;
      pcount   = 0;
      dado5    = '0;
      ocup9    = 1'b1;
      ocup10   = 1'b0;
      pronto18 = 1'b0;
      dado18   = '0;
      for (int i = 1; i <= 19; i++) begin
         bus.iniciar = (i == 3 || i == 9 || i == 10);
         @(posedge clock); #1;
         if (i <= 9 && bus.pronto) pcount++;
         if (i == 8) dado5 = bus.dado_byte;
         if (i == 9) ocup9 = bus.ocupado;
         if (i == 10) ocup10 = bus.ocupado;
         if (i == 18) begin
            pronto18 = bus.pronto;
            dado18   = bus.dado_byte;
         end
      end
      bus.iniciar = 1'b0;
      chk("busy_pronto_count", pcount, 1);
      chk("busy_dado042",      dado5, 8'h2A);
      chk("busy_idle_k9",      ocup9, 1'b0);
      chk("restart_k10",       ocup10, 1'b1);
      chk("restart_pronto",    pronto18, 1'b1);
      chk("restart_dado107",   dado18, 8'h6B);
      chk("restart_inv",       bus.digito_invalido, 1'b0);

      // Plan 6: reset mid-conversion aborts with no pronto
      bus.centenas  = 4'd1;
      bus.dezenas   = 4'd0;
      bus.unitarios = 4'd0;
      bus.iniciar   = 1'b1;
      @(posedge clock); #1;
      bus.iniciar = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk("abort_busy_before", bus.ocupado, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("abort_dado",    bus.dado_byte, 8'h00);
      chk("abort_ocupado", bus.ocupado, 1'b0);
      chk("abort_pronto",  bus.pronto, 1'b0);
      chk("abort_ovf",     bus.overflow, 1'b0);
      pcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if (bus.pronto) pcount++;
      end
      chk("abort_no_pronto", pcount, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      run_conv("c100", 4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
